rgb_seq_mag_cmp: RTL
====================

// Module: rgb_seq_mag_cmp
// PURPOSE
//  Parametrised successor to the 2-bit comparator RGB indicator. Compares two WIDTH-bit operands
//  serially, MSB-first, one bit per clock, in unsigned or two's-complement mode.
//  Drives r/g/b (a>b / a==b / a<b) PWM-dimmed for a fixed hold window, then returns to idle.
//  Sits between a board operand source (switches or a register) and the RGB LED pins.
// PARAMETERS
//  WIDTH        8   operand width in bits, >=2
//  HOLD_CYCLES  16  clocks the result stays displayed, >=1
//  PWM_BITS     4   width of the brightness duty value and of the PWM counter
// PORTS
//  clk          in   1          system clock; all state changes on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  in_valid     in   1          operand pair offered
//  in_ready     out  1          block can accept operands (high only in IDLE)
//  op_a         in   WIDTH      operand A
//  op_b         in   WIDTH      operand B
//  signed_mode  in   1          1: operands are two's complement; sampled with operands
//  duty         in   PWM_BITS   LED brightness; sampled live every cycle
//  res_valid    out  1          one-cycle pulse when the result is decided
//  res_code     out  2          01 LT, 10 EQ, 11 GT, 00 none; held through DISPLAY
//  r, g, b      out  1 each     LED drives: r=GT, g=EQ, b=LT, PWM-gated
// BEHAVIOUR
//  Reset (async assert, clk-synchronous release): state=IDLE, in_ready=1, res_valid=0, res_code=00,
//   r=g=b=0, bit index and hold/PWM counters = 0.
//  FSM IDLE -> CMP -> DISPLAY -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch op_a, op_b, signed_mode; idx=WIDTH-1; go CMP.
//   CMP: in_ready=0. Each cycle inspects bit idx of both latched operands.
//    Bits differ: decide. At idx==WIDTH-1 with signed_mode=1 the operand with bit=1 is LESS;
//     otherwise the operand with bit=1 is GREATER. Go DISPLAY.
//    Bits equal and idx==0: decide EQ; go DISPLAY. Else idx-=1.
//    Latency: decision k+1 cycles after acceptance, k = MSB-first position of the first
//     differing bit; EQ takes WIDTH cycles.
//   DISPLAY entry: res_valid=1 for exactly one cycle; res_code registered; hold counter cleared.
//    Stays HOLD_CYCLES cycles, then IDLE with res_code=00 and LEDs off.
//  LED drive: lit colour = decoded res_code AND pwm_on; pwm_on = (pwm_cnt < duty).
//   pwm_cnt is free-running PWM_BITS wide and wraps.
//   duty=0 -> LED dark; duty=2^PWM_BITS-1 -> on (2^PWM_BITS-1) of every 2^PWM_BITS cycles.
//   Exactly one of r/g/b may be high at any time; all low outside DISPLAY.
//  in_valid while in_ready=0: ignored, not queued. Operand changes after acceptance have no effect.
//  rst_n asserted mid-CMP or mid-DISPLAY: immediate return to reset values; no res_valid pulse.
// STRUCTURE
//  Package rgb_cmp_pkg: typedef enum logic[1:0] state_t {IDLE, CMP, DISPLAY};
//   typedef enum logic[1:0] cmp_res_t {RES_NONE=2'b00, RES_LT=2'b01, RES_EQ=2'b10, RES_GT=2'b11}.
//  Sub-module: pwm_gate #(PWM_BITS) -- free-running counter plus compare, output pwm_on.
//   Shares clk/rst_n.
//  Top holds the FSM, operand latches, bit index counter and hold counter.
// TESTING (WIDTH=8, HOLD_CYCLES=16, PWM_BITS=4)
//  Unsigned a=8'h80, b=8'h7F -> decide on 1st CMP cycle; res_valid pulse;
//   res_code=11; only r toggles.
//  Unsigned a=8'h05, b=8'h07 -> res_code=01 after 7 CMP cycles; b lit; r, g stay 0.
//  a=b=8'hA5 -> EQ after exactly 8 CMP cycles; g lit for 16 cycles; then IDLE, in_ready=1.
//  Signed a=8'hFF (-1), b=8'h01 -> LT (b lit).
//   Same operands unsigned -> GT (r lit).
//  duty=0 -> r/g/b never high; duty=8 -> lit colour high exactly 8 of each 16 cycles.
//  Pulse in_valid during CMP: ignored.
//   Assert rst_n=0 mid-CMP: all outputs 0 at once; no res_valid; next op accepted normally.

Source files
------------

// File: rtl/rgb_cmp_pkg.sv
// Shared types and the bit-decision helper for the serial RGB magnitude comparator.
package rgb_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP     = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_GT   = 2'b11
  } cmp_res_t;

  // Only meaningful when the two bits differ; at the sign position a set bit marks the smaller operand.
  function automatic cmp_res_t bit_decide(input logic a_bit, input logic sign_pos);
    cmp_res_t res;
    if (sign_pos) begin
      res = a_bit ? RES_LT : RES_GT;
    end else begin
      res = a_bit ? RES_GT : RES_LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_seq_mag_cmp_pwm_gate.sv
// Free-running PWM counter; pwm_on_o is high while the count is below the live duty value.
module pwm_gate #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  // Counter wraps naturally at 2^PWM_BITS.
  always_comb begin
    cnt_d = cnt_q + PWM_BITS'(1);
  end

  // PWM counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {PWM_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwm_on_o = (cnt_q < duty_i);

endmodule

// File: rtl/rgb_seq_mag_cmp.sv
// Serial MSB-first magnitude comparator (unsigned / two's complement) driving PWM-dimmed RGB result LEDs.
module rgb_seq_mag_cmp
  import rgb_cmp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic                signed_mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                res_valid,
  output logic [1:0]          res_code,
  output logic                r,
  output logic                g,
  output logic                b
);

  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  cmp_res_t           code_q, code_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               r_q, r_d, g_q, g_d, b_q_led, b_d_led;
  logic               a_bit_s, b_bit_s;
  logic               pwm_on;

  pwm_gate #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty_i   (duty),
    .pwm_on_o (pwm_on)
  );

  // Next-state logic for the IDLE -> CMP -> DISPLAY sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    code_d  = code_q;
    valid_d = 1'b0;
    ready_d = ready_q;
    a_bit_s = a_q[idx_q];
    b_bit_s = b_q[idx_q];
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          sgn_d   = signed_mode;
          idx_d   = IDX_MSB;
          ready_d = 1'b0;
          state_d = CMP;
        end else begin
          code_d  = RES_NONE;
        end
      end
      CMP: begin
        if (a_bit_s != b_bit_s) begin
          code_d  = bit_decide(a_bit_s, sgn_q && (idx_q == IDX_MSB));
          valid_d = 1'b1;
          hold_d  = {HOLD_W{1'b0}};
          state_d = DISPLAY;
        end else if (idx_q == {IDX_W{1'b0}}) begin
          code_d  = RES_EQ;
          valid_d = 1'b1;
          hold_d  = {HOLD_W{1'b0}};
          state_d = DISPLAY;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
        end
      end
      DISPLAY: begin
        if (hold_q == HOLD_LAST) begin
          code_d  = RES_NONE;
          hold_d  = {HOLD_W{1'b0}};
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        code_d  = RES_NONE;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    // LEDs follow the result being registered this edge, so they go dark together with res_code.
    r_d     = (code_d == RES_GT) && pwm_on;
    g_d     = (code_d == RES_EQ) && pwm_on;
    b_d_led = (code_d == RES_LT) && pwm_on;
  end

  // FSM, operand latches, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sgn_q   <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      code_q  <= RES_NONE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q_led <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q_led <= b_d_led;
    end
  end

  assign in_ready  = ready_q;
  assign res_valid = valid_q;
  assign res_code  = code_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q_led;

endmodule
